// File: rtl/pq_pkg.sv
// pq_pkg: shared operation/state encodings and default sizing for the
// priority-queue arbiter slice.
package pq_pkg;

  typedef enum logic {
    OP_ENQ = 1'b0,
    OP_DEQ = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int DEF_KW    = 8;
  localparam int DEF_DEPTH = 16;

endpackage

// File: rtl/pq_arbiter_rr.sv
// rr_arbiter: rotating-priority one-hot grant over an eligibility mask; the
// pointer names the highest-priority requester and moves past each grant.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] elig,
  input  logic            adv,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic          found;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end else begin
      sum = sum;
    end
    return IW'(sum);
  endfunction

  // first eligible requester at or after the pointer wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      if (!found && elig[wrap_add(ptr_q, off)]) begin
        found   = 1'b1;
        gnt_idx = wrap_add(ptr_q, off);
      end else begin
        found = found;
      end
    end
    gnt[gnt_idx] = found;
  end

  always_comb begin
    if (adv) begin
      ptr_d = wrap_add(gnt_idx, 1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/pq_arbiter.sv
// pq_arbiter: serialises requester ENQ/DEQ traffic onto one priority-queue port,
// tracks occupancy, routes dequeued keys back, flushes, and monitors min-first order.
module pq_arbiter
  import pq_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int KW      = DEF_KW,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int DEQ_LAT = 2,
  parameter int IW      = $clog2(NREQ),
  parameter int CW      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_op,
  input  logic [NREQ*KW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               pq_enq,
  output logic               pq_deq,
  output logic [KW-1:0]      pq_din,
  input  logic [KW-1:0]      pq_dout,
  output logic               rsp_valid,
  output logic [IW-1:0]      rsp_id,
  output logic [KW-1:0]      rsp_data,
  input  logic               flush,
  output logic               flush_done,
  output logic [CW-1:0]      count,
  output logic               order_err
);

  state_e state_q, state_d;

  logic [CW-1:0] count_q, count_d;
  logic          pq_enq_q, pq_enq_d;
  logic          pq_deq_q, pq_deq_d;
  logic [KW-1:0] pq_din_q, pq_din_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [IW-1:0] rsp_id_q, rsp_id_d;
  logic [KW-1:0] rsp_data_q, rsp_data_d;
  logic          flush_done_q, flush_done_d;
  logic          order_err_q, order_err_d;
  logic [KW-1:0] last_key_q, last_key_d;
  logic          last_vld_q, last_vld_d;

  // stage DEQ_LAT lines up with pq_dout; disc marks flush dequeues to drop
  logic [DEQ_LAT:0]         pipe_vld_q, pipe_vld_d;
  logic [DEQ_LAT:0]         pipe_disc_q, pipe_disc_d;
  logic [DEQ_LAT:0][IW-1:0] pipe_id_q, pipe_id_d;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            grant;
  op_e             gnt_op;
  logic [KW-1:0]   gnt_data;
  logic            enq_grant;
  logic            deq_grant;
  logic            issue_deq;
  logic            run_grant_en;
  logic            flush_issue;
  logic            pipe_drain;
  logic            deliver;

  rr_arbiter #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .elig   (elig),
    .adv    (grant),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     state_d = flush ? FLUSH : RUN;
      FLUSH:   state_d = (count_q == '0) ? WAIT : FLUSH;
      WAIT:    state_d = flush_done_q ? RUN : WAIT;
      default: state_d = RUN;
    endcase
  end

  // in WAIT only older stages can still hold work, so this predicts "empty next cycle"
  always_comb begin
    run_grant_en = 1'b0;
    flush_issue  = 1'b0;
    flush_done_d = 1'b0;
    pipe_drain   = ~|pipe_vld_q[DEQ_LAT-1:0];
    case (state_q)
      RUN:     run_grant_en = !flush;
      FLUSH:   flush_issue  = (count_q != '0);
      WAIT:    flush_done_d = pipe_drain && !flush_done_q;
      default: run_grant_en = 1'b0;
    endcase
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_op[i] == OP_DEQ) begin
        elig[i] = run_grant_en && req_valid[i] && (count_q != '0);
      end else begin
        elig[i] = run_grant_en && req_valid[i] && (count_q < CW'(DEPTH));
      end
    end
  end

  always_comb begin
    grant     = |gnt;
    gnt_op    = op_e'(req_op[gnt_idx]);
    gnt_data  = req_data[int'(gnt_idx)*KW +: KW];
    enq_grant = grant && (gnt_op == OP_ENQ);
    deq_grant = grant && (gnt_op == OP_DEQ);
    issue_deq = deq_grant || flush_issue;
  end

  always_comb begin
    if (enq_grant) begin
      count_d = count_q + CW'(1);
    end else if (issue_deq) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end

    pq_enq_d = enq_grant;
    pq_deq_d = issue_deq;
    pq_din_d = enq_grant ? gnt_data : '0;

    pipe_vld_d  = {pipe_vld_q[DEQ_LAT-1:0], issue_deq};
    pipe_disc_d = {pipe_disc_q[DEQ_LAT-1:0], flush_issue};
    pipe_id_d   = {pipe_id_q[DEQ_LAT-1:0], gnt_idx};

    deliver     = pipe_vld_q[DEQ_LAT] && !pipe_disc_q[DEQ_LAT];
    rsp_valid_d = deliver;
    rsp_id_d    = deliver ? pipe_id_q[DEQ_LAT] : '0;
    rsp_data_d  = deliver ? pq_dout : '0;

    // a fresh enqueue may legitimately introduce a smaller key
    order_err_d = order_err_q || (deliver && last_vld_q && (pq_dout < last_key_q));
    last_key_d  = deliver ? pq_dout : last_key_q;
    if (enq_grant) begin
      last_vld_d = 1'b0;
    end else if (deliver) begin
      last_vld_d = 1'b1;
    end else begin
      last_vld_d = last_vld_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      pq_enq_q     <= 1'b0;
      pq_deq_q     <= 1'b0;
      pq_din_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      flush_done_q <= 1'b0;
      order_err_q  <= 1'b0;
      last_key_q   <= '0;
      last_vld_q   <= 1'b0;
      pipe_vld_q   <= '0;
      pipe_disc_q  <= '0;
      pipe_id_q    <= '0;
    end else begin
      count_q      <= count_d;
      pq_enq_q     <= pq_enq_d;
      pq_deq_q     <= pq_deq_d;
      pq_din_q     <= pq_din_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      flush_done_q <= flush_done_d;
      order_err_q  <= order_err_d;
      last_key_q   <= last_key_d;
      last_vld_q   <= last_vld_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_disc_q  <= pipe_disc_d;
      pipe_id_q    <= pipe_id_d;
    end
  end

  assign req_ready  = gnt;
  assign pq_enq     = pq_enq_q;
  assign pq_deq     = pq_deq_q;
  assign pq_din     = pq_din_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign flush_done = flush_done_q;
  assign count      = count_q;
  assign order_err  = order_err_q;

endmodule

// File: tb/tb_pq_arbiter.sv
// tb_pq_arbiter: directed bench for pq_arbiter; a small behavioural min-queue
// with a two-cycle read path stands in for the PQ core.
module tb_pq_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        pq_enq;
  logic        pq_deq;
  logic [7:0]  pq_din;
  logic [7:0]  pq_dout;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        flush;
  logic        flush_done;
  logic [4:0]  count;
  logic        order_err;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] mq[$];
  logic [7:0] s1, s2, popped;
  int         mi;
  logic [7:0] ovr_v[2];
  int         ovr_i = 0;
  int         ovr_n = 0;

  pq_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_ready (req_ready),
    .pq_enq    (pq_enq),
    .pq_deq    (pq_deq),
    .pq_din    (pq_din),
    .pq_dout   (pq_dout),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .flush     (flush),
    .flush_done(flush_done),
    .count     (count),
    .order_err (order_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model PQ: a dequeue seen in cycle c is presented on pq_dout during cycle c+2
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      s1 = 8'h00;
      s2 = 8'h00;
      pq_dout = 8'h00;
    end else begin
      pq_dout = s2;
      s2 = s1;
      s1 = 8'h00;
      if (pq_deq) begin
        popped = 8'h00;
        if (mq.size() > 0) begin
          mi = 0;
          for (int j = 1; j < mq.size(); j++) begin
            if (mq[j] < mq[mi]) mi = j;
          end
          popped = mq[mi];
          mq.delete(mi);
        end
        if (ovr_n > 0) begin
          popped = ovr_v[ovr_i];
          ovr_i++;
          ovr_n--;
        end
        s1 = popped;
      end
      if (pq_enq) mq.push_back(pq_din);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic set_key(input int i, input logic [7:0] k);
    req_data[i*8 +: 8] = k;
  endtask

  task automatic clr_inputs();
    req_valid = 4'b0000;
    req_op    = 4'b0000;
    req_data  = 32'h0;
    flush     = 1'b0;
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_ready"},  {28'h0, req_ready}, 32'h0);
    chk({p, "_enq"},    {31'h0, pq_enq}, 32'h0);
    chk({p, "_deq"},    {31'h0, pq_deq}, 32'h0);
    chk({p, "_din"},    {24'h0, pq_din}, 32'h0);
    chk({p, "_rspv"},   {31'h0, rsp_valid}, 32'h0);
    chk({p, "_rspid"},  {30'h0, rsp_id}, 32'h0);
    chk({p, "_rspd"},   {24'h0, rsp_data}, 32'h0);
    chk({p, "_fdone"},  {31'h0, flush_done}, 32'h0);
    chk({p, "_count"},  {27'h0, count}, 32'h0);
    chk({p, "_oerr"},   {31'h0, order_err}, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic enq_r0(input logic [7:0] k);
    nxt();
    req_valid = 4'b0001;
    req_op    = 4'b0000;
    set_key(0, k);
    #1 chk("enq_ready", {28'h0, req_ready}, 32'h1);
  endtask

  task automatic order_case(input string tg, input logic [7:0] a, input logic [7:0] b,
                            input logic exp_err);
    do_reset();
    enq_r0(8'h50);
    enq_r0(8'h60);
    ovr_v[0] = a;
    ovr_v[1] = b;
    ovr_i = 0;
    ovr_n = 2;
    nxt(); req_valid = 4'b0010; req_op = 4'b0010;
    #1 chk({tg, "_g0"}, {28'h0, req_ready}, 32'h2);
    nxt();
    #1 chk({tg, "_g1"}, {28'h0, req_ready}, 32'h2);
    nxt(); req_valid = 4'b0000;
    nxt();
    nxt();
    chk({tg, "_rv0"},  {31'h0, rsp_valid}, 32'h1);
    chk({tg, "_rd0"},  {24'h0, rsp_data}, {24'h0, a});
    chk({tg, "_oe0"},  {31'h0, order_err}, 32'h0);
    nxt();
    chk({tg, "_rd1"},  {24'h0, rsp_data}, {24'h0, b});
    chk({tg, "_oe1"},  {31'h0, order_err}, {31'h0, exp_err});
    nxt();
    chk({tg, "_oe2"},  {31'h0, order_err}, {31'h0, exp_err});
    chk({tg, "_rv2"},  {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) @(negedge clk);
    #1 check_reset_vals("rst");
    rst_n = 1'b1;

    // three requesters valid at once; the DEQ waits until something is queued
    nxt(); req_valid = 4'b0111; req_op = 4'b0100;
    set_key(0, 8'h30); set_key(1, 8'h10);
    #1 chk("s1_gnt0", {28'h0, req_ready}, 32'h1);
    nxt();
    chk("s1_enq", {31'h0, pq_enq}, 32'h1);
    chk("s1_din0", {24'h0, pq_din}, 32'h30);
    req_valid = 4'b0110;
    #1 chk("s1_gnt1", {28'h0, req_ready}, 32'h2);
    nxt();
    chk("s1_din1", {24'h0, pq_din}, 32'h10);
    req_valid = 4'b0100;
    #1 chk("s1_gnt2", {28'h0, req_ready}, 32'h4);
    nxt();
    chk("s1_deq", {31'h0, pq_deq}, 32'h1);
    req_valid = 4'b0000;
    nxt();
    nxt();
    chk("s1_rv_early", {31'h0, rsp_valid}, 32'h0);
    nxt();
    chk("s1_rv", {31'h0, rsp_valid}, 32'h1);
    chk("s1_rid", {30'h0, rsp_id}, 32'h2);
    chk("s1_rd", {24'h0, rsp_data}, 32'h10);
    chk("s1_count", {27'h0, count}, 32'h1);

    // fill to DEPTH through requester 2, leaving the pointer on requester 3
    for (int j = 0; j < 15; j++) begin
      nxt(); req_valid = 4'b0100; req_op = 4'b0000;
      set_key(2, 8'h40 + 8'(j));
      #1 chk("s2_fill", {28'h0, req_ready}, 32'h4);
    end
    nxt();
    chk("s2_full", {27'h0, count}, 32'h10);
    req_valid = 4'b1000; req_op = 4'b0010; set_key(3, 8'h55);
    #1 chk("s2_full_enq", {28'h0, req_ready}, 32'h0);
    req_valid = 4'b1010;
    #1 chk("s2_skip3", {28'h0, req_ready}, 32'h2);
    nxt();
    chk("s2_cnt15", {27'h0, count}, 32'hf);
    req_valid = 4'b1000;
    #1 chk("s2_gnt3", {28'h0, req_ready}, 32'h8);
    nxt();
    req_valid = 4'b0000;
    chk("s2_cnt16", {27'h0, count}, 32'h10);
    nxt();
    nxt();
    chk("s2_rv", {31'h0, rsp_valid}, 32'h1);
    chk("s2_rid", {30'h0, rsp_id}, 32'h1);
    chk("s2_rd", {24'h0, rsp_data}, 32'h30);

    // empty queue: every DEQ is ineligible
    do_reset();
    nxt(); req_valid = 4'b1111; req_op = 4'b1111;
    #1 chk("s3_ready", {28'h0, req_ready}, 32'h0);
    for (int j = 0; j < 3; j++) begin
      nxt();
      chk("s3_deq", {31'h0, pq_deq}, 32'h0);
      chk("s3_count", {27'h0, count}, 32'h0);
      chk("s3_ready_h", {28'h0, req_ready}, 32'h0);
    end

    // flush with five entries; requester 0 keeps asking throughout
    do_reset();
    enq_r0(8'h05); enq_r0(8'h04); enq_r0(8'h03); enq_r0(8'h02); enq_r0(8'h01);
    nxt();
    chk("s4_cnt5", {27'h0, count}, 32'h5);
    flush = 1'b1;
    #1 chk("s4_flush_rdy", {28'h0, req_ready}, 32'h0);
    nxt();
    flush = 1'b0;
    #1 chk("s4_f0_rdy", {28'h0, req_ready}, 32'h0);
    for (int k = 1; k <= 9; k++) begin
      nxt();
      chk("s4_deq", {31'h0, pq_deq}, (k <= 5) ? 32'h1 : 32'h0);
      chk("s4_rv", {31'h0, rsp_valid}, 32'h0);
      chk("s4_fdone", {31'h0, flush_done}, (k == 8) ? 32'h1 : 32'h0);
      if (k == 6) chk("s4_cnt0", {27'h0, count}, 32'h0);
      #1 chk("s4_rdy", {28'h0, req_ready}, (k == 9) ? 32'h1 : 32'h0);
    end
    nxt();
    req_valid = 4'b0000;
    chk("s4_resume", {27'h0, count}, 32'h1);

    // order monitor: a decrease is flagged, equal keys are not
    order_case("s5_dec", 8'h20, 8'h18, 1'b1);
    order_case("s5_eq", 8'h20, 8'h20, 1'b0);

    // reset one cycle after a DEQ grant discards the in-flight response
    do_reset();
    enq_r0(8'h33);
    nxt(); req_valid = 4'b0100; req_op = 4'b0100;
    #1 chk("s6_gnt", {28'h0, req_ready}, 32'h4);
    nxt();
    chk("s6_deq", {31'h0, pq_deq}, 32'h1);
    rst_n = 1'b0;
    clr_inputs();
    #1 check_reset_vals("s6_rst");
    nxt();
    nxt();
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      nxt();
      chk("s6_no_rsp", {31'h0, rsp_valid}, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
